data_cache: RTL

- Data-memory-side cache for the pipelined RV32 CPU. Sits in the MEM stage.
- Consumes the MEM_READ/MEM_WRITE size codes carried down the pipeline registers.
- Produces BUSY_WAIT, which stalls every pipeline register.
- Direct-mapped, write-back, write-allocate. Refills and evicts 128-bit blocks over a req/ack handshake to main data memory.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_lane_select.sv | 61 ++++++
 rtl/data_cache.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the MEM-stage data cache: access codes, FSM states, block width.
package dcache_pkg;

  localparam int BLOCK_W = 128;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_SB   = 3'd1;
  localparam logic [2:0] ST_SH   = 3'd2;
  localparam logic [2:0] ST_SW   = 3'd3;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE, UPDATE} state_e;

  function automatic logic ld_legal(input logic [2:0] code);
    return (code != LD_NONE) && (code <= LD_LHU);
  endfunction

  function automatic logic st_legal(input logic [2:0] code);
    return (code != ST_NONE) && (code <= ST_SW);
  endfunction

endpackage

// File: rtl/dcache_lane_select.sv
// Word/half/byte extraction with load extension, and the store merge of new data
// into the addressed word of a cache line.
module dcache_lane_select
  import dcache_pkg::*;
(
  input  logic [BLOCK_W-1:0] line_i,
  input  logic [1:0]         word_i,
  input  logic [1:0]         byte_i,
  input  logic [2:0]         ld_code_i,
  input  logic [2:0]         st_code_i,
  input  logic [31:0]        st_data_i,
  output logic [31:0]        ld_data_o,
  output logic [31:0]        st_word_o
);

  logic [31:0] word;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] st_mask;
  logic [31:0] st_rep;

  always_comb begin
    word   = line_i[{word_i, 5'd0} +: 32];
    byte_v = word[{byte_i, 3'd0} +: 8];
    // Halfword alignment uses ADDRESS[1] only; ADDRESS[0] is ignored.
    half_v = byte_i[1] ? word[31:16] : word[15:0];

    ld_data_o = '0;
    case (ld_code_i)
      LD_LB:   ld_data_o = {{24{byte_v[7]}}, byte_v};
      LD_LH:   ld_data_o = {{16{half_v[15]}}, half_v};
      LD_LW:   ld_data_o = word;
      LD_LBU:  ld_data_o = {24'd0, byte_v};
      LD_LHU:  ld_data_o = {16'd0, half_v};
      default: ld_data_o = '0;
    endcase

    st_mask = '0;
    st_rep  = '0;
    case (st_code_i)
      ST_SB: begin
        st_mask = 32'h0000_00FF << {byte_i, 3'd0};
        st_rep  = {4{st_data_i[7:0]}};
      end
      ST_SH: begin
        st_mask = byte_i[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        st_rep  = {2{st_data_i[15:0]}};
      end
      ST_SW: begin
        st_mask = 32'hFFFF_FFFF;
        st_rep  = st_data_i;
      end
      default: begin
        st_mask = '0;
        st_rep  = '0;
      end
    endcase
    st_word_o = (word & ~st_mask) | (st_rep & st_mask);
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache for the MEM stage.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT outputs.
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [2:0]         MEM_READ,
  input  logic [2:0]         MEM_WRITE,
  input  logic [31:0]        ADDRESS,
  input  logic [31:0]        WRITE_DATA,
  output logic [31:0]        READ_DATA,
  output logic               BUSY_WAIT,
  output logic               MEM_READ_REQ,
  output logic               MEM_WRITE_REQ,
  output logic [27:0]        MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITE_DATA,
  input  logic [BLOCK_W-1:0] MEM_READ_DATA,
  input  logic               MEM_ACK
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        HIT_COUNT,
  output logic [31:0]        MISS_COUNT
`endif
);

  localparam int INDEX_W = $clog2(NUM_SETS);
  localparam int TAG_W   = 28 - INDEX_W;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [1:0]         word_sel;
  logic [1:0]         byte_sel;

  state_e                    state_q, state_d;
  logic [NUM_SETS-1:0]       valid_q, valid_d;
  logic [NUM_SETS-1:0]       dirty_q, dirty_d;
  logic [TAG_W-1:0]          tag_q  [NUM_SETS];
  logic [TAG_W-1:0]          tag_d  [NUM_SETS];
  logic [BLOCK_W-1:0]        data_q [NUM_SETS];
  logic [BLOCK_W-1:0]        data_d [NUM_SETS];

  logic        ld_ok, st_ok, access, rd_active, hit;
  logic [31:0] ld_data, st_word;

  assign idx      = ADDRESS[4 +: INDEX_W];
  assign tag      = ADDRESS[31 -: TAG_W];
  assign word_sel = ADDRESS[3:2];
  assign byte_sel = ADDRESS[1:0];

  // A store and a load in the same cycle: the store wins and the load is dropped.
  assign ld_ok     = ld_legal(MEM_READ);
  assign st_ok     = st_legal(MEM_WRITE);
  assign access    = ld_ok | st_ok;
  assign rd_active = ld_ok & ~st_ok;
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);

  dcache_lane_select u_lane (
    .line_i    (data_q[idx]),
    .word_i    (word_sel),
    .byte_i    (byte_sel),
    .ld_code_i (rd_active ? MEM_READ : LD_NONE),
    .st_code_i (st_ok ? MEM_WRITE : ST_NONE),
    .st_data_i (WRITE_DATA),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (hit) begin
            if (st_ok) begin
              data_d[idx][{word_sel, 5'd0} +: 32] = st_word;
              dirty_d[idx] = 1'b1;
            end
          end else begin
            state_d = (valid_q[idx] && dirty_q[idx]) ? WRITE_BACK : ALLOCATE;
          end
        end
      end
      WRITE_BACK: if (MEM_ACK) state_d = ALLOCATE;
      ALLOCATE: begin
        if (MEM_ACK) begin
          data_d[idx]  = MEM_READ_DATA;
          tag_d[idx]   = tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = UPDATE;
        end
      end
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line storage needs no reset: valid bits guard it.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  // Memory-side outputs decode straight from state, so they drop the edge after ACK or RESET.
  always_comb begin
    MEM_READ_REQ   = (state_q == ALLOCATE);
    MEM_WRITE_REQ  = (state_q == WRITE_BACK);
    MEM_ADDRESS    = '0;
    MEM_WRITE_DATA = '0;
    if (state_q == WRITE_BACK) begin
      MEM_ADDRESS    = {tag_q[idx], idx};
      MEM_WRITE_DATA = data_q[idx];
    end else if (state_q == ALLOCATE) begin
      MEM_ADDRESS = ADDRESS[31:4];
    end
  end

  assign BUSY_WAIT = ~RESET && ((state_q != IDLE) || (access && ~hit));
  assign READ_DATA = (~RESET && rd_active && hit) ? ld_data : 32'd0;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        refill_done_q, refill_done_d;

  // The hit that follows a refill belongs to an already-counted miss.
  always_comb begin
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    refill_done_d = (state_q == UPDATE);
    if (state_q == IDLE && access) begin
      if (hit && !refill_done_q && hit_cnt_q != 32'hFFFF_FFFF)
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (!hit && miss_cnt_q != 32'hFFFF_FFFF)
        miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      refill_done_q <= 1'b0;
    end else begin
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      refill_done_q <= refill_done_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
